// File: rtl/dmem_responder_if.sv
// Core-side data-memory bus between the RV32I load/store unit and the responder.
// The master drives the request; the slave returns read data and the ready handshake.
interface dmem_responder_if;
    logic [31:0] mem_addr;
    logic        mem_oe;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_addr,
        output mem_oe,
        output mem_wdata,
        output mem_we,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_oe,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-wide on-chip data RAM behind the core's byte-addressed load/store port,
// with lane alignment, sticky error flags and a configurable read latency.
//
// state | meaning
// IDLE  | mem_ready high, one request accepted per edge
// WAIT  | load pending, cnt_q counts down to completion, requests ignored
module dmem_responder #(
    parameter int unsigned AW        = 14,
    parameter logic [31:0] BASE      = 32'h0000_0000,
    parameter int unsigned LATENCY   = 1,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_responder_if.slave   mem,
    input  logic              err_clr_i,
    output logic              err_misalign_o,
    output logic              err_range_o
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic [AW-1:0]   idx_q;
    logic [1:0]      off_q;
    logic            oor_q;
    logic [31:0]     rdata_q;
    logic            mis_q;
    logic            rng_q;

    logic [31:0]     ram [0:(1 << AW) - 1];

    logic [AW-1:0]   req_idx;
    logic [1:0]      req_off;
    logic            req_hit;
    logic            req_store;
    logic            req_mis;
    logic            accept;
    logic            do_write;
    logic [3:0]      lane;
    logic [31:0]     wdata_sh;
    logic [31:0]     word_now;
    logic [31:0]     word_pend;
    logic [31:0]     rdata_d;

    assign req_idx   = mem.mem_addr[AW+1:2];
    assign req_off   = mem.mem_addr[1:0];
    assign req_hit   = (mem.mem_addr[31:AW+2] == BASE[31:AW+2]);
    assign req_store = |mem.mem_we;
    // Load width is unknown here, so only stores can be flagged misaligned.
    assign req_mis   = req_store &&
                       (((mem.mem_we == 4'b0011) && req_off[0]) ||
                        ((mem.mem_we == 4'b1111) && (req_off != 2'd0)));
    assign accept    = (state_q == IDLE) && mem.mem_oe;
    assign do_write  = rst_n && accept && req_store && req_hit && !req_mis;
    assign lane      = mem.mem_we << req_off;
    assign wdata_sh  = mem.mem_wdata << {req_off, 3'b000};

    assign word_now  = ram[req_idx];
    assign word_pend = ram[idx_q];

    always_comb begin
        rdata_d = '0;
        if (state_q == IDLE) begin
            if (req_hit) rdata_d = word_now >> {req_off, 3'b000};
        end else if (!oor_q) begin
            rdata_d = word_pend >> {off_q, 3'b000};
        end
    end

    // RAM keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (lane[b]) ram[req_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            oor_q   <= 1'b0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            rng_q   <= 1'b0;
        end else begin
            if (err_clr_i) begin
                mis_q <= 1'b0;
                rng_q <= 1'b0;
            end else if (accept) begin
                if (req_mis)  mis_q <= 1'b1;
                if (!req_hit) rng_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (accept && !req_store) begin
                        if (LATENCY <= 1) begin
                            rdata_q <= rdata_d;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                            idx_q   <= req_idx;
                            off_q   <= req_off;
                            oor_q   <= !req_hit;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        rdata_q <= rdata_d;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem.mem_ready  = (state_q == IDLE);
    assign mem.mem_rdata  = rdata_q;
    assign err_misalign_o = mis_q;
    assign err_range_o    = rng_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and random bench for dmem_responder: five instances with LATENCY 1..5
// share one stimulus bus, only the selected one sees mem_oe.
module tb_dmem_responder;

    localparam int NDUT = 5;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic        oe;
    logic [31:0] wdata;
    logic [3:0]  wen;
    logic        err_clr;
    int          sel;

    logic [NDUT-1:0] rdy_a;
    logic [NDUT-1:0] mis_a;
    logic [NDUT-1:0] rng_a;
    logic [31:0]     rd_a [NDUT];

    int n_assert = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;

    logic [7:0]      refm [NDUT][1024];
    bit [NDUT-1:0]   emis;
    bit [NDUT-1:0]   erng;
    logic [31:0]     sb [$];
    logic [31:0]     lane_exp [4];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dmem_responder_if u_if ();

        assign u_if.mem_addr  = addr;
        assign u_if.mem_oe    = oe && (sel == g);
        assign u_if.mem_wdata = wdata;
        assign u_if.mem_we    = wen;
        assign rdy_a[g]       = u_if.mem_ready;
        assign rd_a[g]        = u_if.mem_rdata;

        dmem_responder #(
            .AW        (14),
            .BASE      (32'h0000_0000),
            .LATENCY   (g + 1),
            .INIT_FILE ("")
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .mem            (u_if),
            .err_clr_i      (err_clr),
            .err_misalign_o (mis_a[g]),
            .err_range_o    (rng_a[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: time limit reached, assertions %0d failures %0d", n_assert, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        if (oe && rdy_a[sel]) acc_cnt++;
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour of one accepted request.
    task automatic model_accept(input int s, input logic [31:0] a, input logic [3:0] we,
                                input logic [31:0] wd);
        logic [1:0]  off;
        int          base;
        bit          hit;
        bit          mis;
        logic [3:0]  m;
        logic [31:0] ws;
        logic [31:0] word;
        off  = a[1:0];
        base = int'(a[9:2]) * 4;
        hit  = (a[31:16] == 16'h0);
        if (we == 4'h0) begin
            word = {refm[s][base+3], refm[s][base+2], refm[s][base+1], refm[s][base]};
            sb.push_back(hit ? (word >> (8 * off)) : 32'h0);
            if (!hit) erng[s] = 1'b1;
        end else begin
            mis = ((we == 4'b0011) && off[0]) || ((we == 4'b1111) && (off != 2'd0));
            if (mis)  emis[s] = 1'b1;
            if (!hit) erng[s] = 1'b1;
            if (!mis && hit) begin
                m  = we << off;
                ws = wd << (8 * off);
                for (int b = 0; b < 4; b++) begin
                    if (m[b]) refm[s][base+b] = ws[8*b +: 8];
                end
            end
        end
    endtask

    task automatic xact(input int s, input logic [31:0] a, input logic [3:0] we,
                        input logic [31:0] wd);
        int waited;
        logic [31:0] exp;
        sel   = s;
        addr  = a;
        wen   = we;
        wdata = wd;
        oe    = 1'b1;
        waited = 0;
        while (rdy_a[s] !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        check("req_ready", rdy_a[s], 1'b1);
        model_accept(s, a, we, wd);
        step();
        oe = 1'b0;
        if (we == 4'h0) begin
            waited = 0;
            while (rdy_a[s] !== 1'b1 && waited < 20) begin
                step();
                waited++;
            end
            check("load_latency", waited, s);
            exp = sb.pop_front();
            check("load_data", rd_a[s], exp);
        end
        check("err_misalign", mis_a[s], emis[s]);
        check("err_range", rng_a[s], erng[s]);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  we;
        int          lat_sel [3];
        lane_exp  = '{32'hDD11_7766, 32'h00DD_1177, 32'h0000_DD11, 32'h0000_00DD};
        lat_sel   = '{0, 1, 4};
        rst_n     = 1'b0;
        addr      = '0;
        oe        = 1'b0;
        wdata     = '0;
        wen       = '0;
        err_clr   = 1'b0;
        sel       = 0;
        emis      = '0;
        erng      = '0;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("reset_ready", rdy_a[2], 1'b1);
        check("reset_rdata", rd_a[2], 32'h0);
        check("reset_misalign", mis_a[0], 1'b0);
        check("reset_range", rng_a[0], 1'b0);

        // Known contents in the first 1 KB of every instance.
        for (int s = 0; s < NDUT; s++) begin
            for (int w = 0; w < 256; w++) begin
                sel   = s;
                addr  = 32'(w * 4);
                wen   = 4'hF;
                wdata = {8'hA5, 8'(w), 8'h5A, 8'(~w)};
                oe    = 1'b1;
                model_accept(s, addr, wen, wdata);
                step();
            end
        end
        oe = 1'b0;

        // Reset while a load is pending (LATENCY 3).
        xact(2, 32'h44, 4'h0, 32'h0);
        xact(2, 32'h0002_0000, 4'hF, 32'h1357_9BDF);
        sel  = 2;
        addr = 32'h40;
        wen  = 4'h0;
        oe   = 1'b1;
        step();
        oe = 1'b0;
        check("rst_pre_wait", rdy_a[2], 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_async_ready", rdy_a[2], 1'b1);
        check("rst_async_rdata", rd_a[2], 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        emis = '0;
        erng = '0;
        step();
        step();
        check("rst_ready", rdy_a[2], 1'b1);
        check("rst_rdata", rd_a[2], 32'h0);
        check("rst_misalign", mis_a[2], 1'b0);
        check("rst_range", rng_a[2], 1'b0);
        xact(2, 32'h0, 4'h0, 32'h0);
        check("rst_ram_kept", rd_a[2], 32'hA500_5AFF);

        // Byte lanes (LATENCY 1).
        xact(0, 32'h100, 4'hF, 32'hDDCC_BBAA);
        xact(0, 32'h102, 4'h1, 32'h0000_0011);
        xact(0, 32'h100, 4'h3, 32'h0000_7766);
        for (int i = 0; i < 4; i++) begin
            xact(0, 32'h100 + 32'(i), 4'h0, 32'h0);
            check("lane_const", rd_a[0], lane_exp[i]);
        end

        // Latency 4 with a store held across the wait, same word as the load.
        sel     = 3;
        acc_cnt = 0;
        addr    = 32'h200;
        wen     = 4'h0;
        oe      = 1'b1;
        model_accept(3, 32'h200, 4'h0, 32'h0);
        step();
        wen   = 4'hF;
        wdata = 32'hCAFE_F00D;
        for (int k = 0; k < 3; k++) begin
            check("l4_ready_low", rdy_a[3], 1'b0);
            step();
        end
        check("l4_ready_high", rdy_a[3], 1'b1);
        check("l4_data", rd_a[3], sb.pop_front());
        model_accept(3, 32'h200, 4'hF, 32'hCAFE_F00D);
        step();
        oe = 1'b0;
        check("l4_accept_count", acc_cnt, 2);
        check("l4_store_no_stall", rdy_a[3], 1'b1);
        xact(3, 32'h200, 4'h0, 32'h0);
        check("l4_store_once", rd_a[3], 32'hCAFE_F00D);

        // Back-to-back loads (LATENCY 1).
        sel = 0;
        wen = 4'h0;
        oe  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            addr = 32'(i * 4);
            model_accept(0, addr, 4'h0, 32'h0);
            step();
            check("b2b_ready", rdy_a[0], 1'b1);
            check("b2b_data", rd_a[0], sb.pop_front());
        end
        oe = 1'b0;

        // Error handling.
        xact(0, 32'h103, 4'b0011, 32'h0000_BEEF);
        check("mis_flag", mis_a[0], 1'b1);
        xact(0, 32'h100, 4'h0, 32'h0);
        check("mis_dropped", rd_a[0], 32'hDD11_7766);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        emis = '0;
        erng = '0;
        check("clr_misalign", mis_a[0], 1'b0);
        check("clr_range", rng_a[0], 1'b0);
        xact(0, 32'h0001_0000, 4'hF, 32'h1234_5678);
        check("rng_flag", rng_a[0], 1'b1);
        xact(0, 32'h0, 4'h0, 32'h0);
        xact(0, 32'h0001_0004, 4'h0, 32'h0);
        check("oor_load_l1", rd_a[0], 32'h0);
        xact(4, 32'h8, 4'h0, 32'h0);
        xact(4, 32'h0001_0008, 4'h0, 32'h0);
        check("oor_load_l5", rd_a[4], 32'h0);
        sel     = 0;
        addr    = 32'h0001_0001;
        wen     = 4'hF;
        wdata   = 32'h5555_AAAA;
        oe      = 1'b1;
        err_clr = 1'b1;
        step();
        oe      = 1'b0;
        err_clr = 1'b0;
        emis = '0;
        erng = '0;
        check("clr_prio_misalign", mis_a[0], 1'b0);
        check("clr_prio_range", rng_a[0], 1'b0);

        // Random traffic at LATENCY 1, 2 and 5.
        for (int li = 0; li < 3; li++) begin
            for (int n = 0; n < 3400; n++) begin
                a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 15) == 0) a = a | (32'($urandom_range(1, 65535)) << 16);
                case ($urandom_range(0, 4))
                    0, 1:    we = 4'h0;
                    2:       we = 4'h1;
                    3:       we = 4'h3;
                    default: we = 4'hF;
                endcase
                xact(lat_sel[li], a, we, $urandom());
                if ((n % 256) == 255) begin
                    err_clr = 1'b1;
                    step();
                    err_clr = 1'b0;
                    emis = '0;
                    erng = '0;
                end
            end
        end

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
